// File: rtl/sample_packetiser.sv
// Sample capture front end: picks ADC or a test source, buffers samples in a FIFO
// and hands them out as left-justified signed 16-bit words to the USB side.
module sample_packetiser #(
    parameter int ADC_WIDTH    = 10,
    parameter int FIFO_DEPTH   = 1024,
    parameter int PACKET_WORDS = 256
) (
    input  logic                          adcClk,
    input  logic                          nReset,
    input  logic                          collectData,
    input  logic                          readData,
    input  logic [1:0]                    testMode,
    input  logic [ADC_WIDTH-1:0]          adcData,
    output logic [15:0]                   dataOut,
    output logic                          dataAvailable,
    output logic                          bufferError,
    output logic [$clog2(FIFO_DEPTH):0]   usedWords
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]          FULL_COUNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]          PKT_COUNT  = (AW+1)'(PACKET_WORDS);
    localparam logic [ADC_WIDTH-1:0] MIDSCALE   = {1'b1, {(ADC_WIDTH-1){1'b0}}};

    logic [ADC_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wrPtr, rdPtr;
    logic [ADC_WIDTH-1:0] ramp;
    logic [15:0]          lfsr;
    logic                 capValid;
    logic [ADC_WIDTH-1:0] capSample;
    logic                 collectPrev;

    logic [ADC_WIDTH-1:0] srcSample;
    logic [ADC_WIDTH-1:0] headFlipped;
    logic                 flush, isEmpty, isFull;
    logic                 doRead, doWrite, overflow, underflow;

    always_comb begin
        srcSample = MIDSCALE;
        case (testMode)
            2'd0:    srcSample = adcData;
            2'd1:    srcSample = ramp;
            2'd2:    srcSample = lfsr[15 -: ADC_WIDTH];
            default: srcSample = MIDSCALE;
        endcase
    end

    // Read protocol: readData is a level pop request sampled each edge; a pop only
    // happens when the FIFO holds data, and the popped word appears on dataOut one
    // cycle later. Reading an empty FIFO is an underflow, even if a write lands in
    // the same cycle (no bypass path).
    assign flush     = collectData & ~collectPrev;
    assign isEmpty   = (usedWords == '0);
    assign isFull    = (usedWords == FULL_COUNT);
    assign doRead    = readData & ~isEmpty & ~flush;
    assign doWrite   = capValid & ~flush & (~isFull | doRead);
    assign overflow  = capValid & isFull & ~readData & ~flush;
    assign underflow = readData & isEmpty & ~flush;

    // Subtracting midscale from an unsigned sample is just an MSB flip.
    assign headFlipped   = mem[rdPtr] ^ MIDSCALE;
    assign dataAvailable = (usedWords >= PKT_COUNT);

    always_ff @(posedge adcClk) begin
        if (doWrite) mem[wrPtr] <= capSample;
    end

    always_ff @(posedge adcClk or negedge nReset) begin
        if (!nReset) begin
            wrPtr       <= '0;
            rdPtr       <= '0;
            usedWords   <= '0;
            dataOut     <= 16'h0000;
            bufferError <= 1'b0;
            ramp        <= '0;
            lfsr        <= 16'hACE1;
            capValid    <= 1'b0;
            capSample   <= '0;
            collectPrev <= 1'b0;
        end else begin
            collectPrev <= collectData;
            if (flush) begin
                wrPtr     <= '0;
                rdPtr     <= '0;
                usedWords <= '0;
            end else begin
                if (doWrite) wrPtr <= wrPtr + AW'(1);
                if (doRead) begin
                    rdPtr   <= rdPtr + AW'(1);
                    dataOut <= 16'(headFlipped) << (16 - ADC_WIDTH);
                end
                if (doWrite && !doRead)      usedWords <= usedWords + (AW+1)'(1);
                else if (doRead && !doWrite) usedWords <= usedWords - (AW+1)'(1);
            end
            bufferError <= collectData ? (bufferError | overflow | underflow) : 1'b0;
            capValid    <= collectData;
            if (collectData) begin
                capSample <= srcSample;
                ramp      <= ramp + ADC_WIDTH'(1);
                lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end
        end
    end

endmodule

// File: tb/tb_sample_packetiser.sv
// Bench for sample_packetiser: conversion vector table, hand-built corner sequences
// and a randomized run against a queue-based reference model.
module tb_sample_packetiser;

    localparam int ADC_WIDTH    = 10;
    localparam int FIFO_DEPTH   = 1024;
    localparam int PACKET_WORDS = 256;
    localparam int UW           = $clog2(FIFO_DEPTH) + 1;

    logic                 adcClk = 1'b0;
    logic                 nReset;
    logic                 collectData;
    logic                 readData;
    logic [1:0]           testMode;
    logic [ADC_WIDTH-1:0] adcData;
    logic [15:0]          dataOut;
    logic                 dataAvailable;
    logic                 bufferError;
    logic [UW-1:0]        usedWords;

    int testsRun = 0;
    int testsFailed = 0;

    sample_packetiser #(
        .ADC_WIDTH(ADC_WIDTH), .FIFO_DEPTH(FIFO_DEPTH), .PACKET_WORDS(PACKET_WORDS)
    ) dut (
        .adcClk(adcClk), .nReset(nReset), .collectData(collectData), .readData(readData),
        .testMode(testMode), .adcData(adcData), .dataOut(dataOut),
        .dataAvailable(dataAvailable), .bufferError(bufferError), .usedWords(usedWords)
    );

    always #5 adcClk = ~adcClk;

    // Reference model: sample queue plus source state, stepped once per clock edge.
    logic [15:0] expQ[$];
    bit          mCapValid;
    int          mCapSample;
    int          mRamp;
    int          mLfsr;
    bit          mPrev;
    int          mOut;
    bit          mErr;

    function automatic int toSigned16(int s);
        return ((s - (1 << (ADC_WIDTH - 1))) << (16 - ADC_WIDTH)) & 16'hFFFF;
    endfunction

    task automatic modelReset();
        expQ.delete();
        mCapValid = 0; mCapSample = 0; mRamp = 0; mLfsr = 16'hACE1;
        mPrev = 0; mOut = 0; mErr = 0;
    endtask

    task automatic modelUpdate();
        bit flush, canPop, ov, un;
        int sz, src;
        flush = collectData && !mPrev;
        sz = expQ.size();
        ov = 0; un = 0;
        if (flush) begin
            expQ.delete();
        end else begin
            canPop = readData && sz > 0;
            un = readData && sz == 0;
            if (canPop) mOut = toSigned16(int'(expQ.pop_front()));
            if (mCapValid) begin
                if (sz < FIFO_DEPTH || canPop) expQ.push_back(16'(mCapSample));
                else ov = 1;
            end
        end
        mErr = collectData ? (mErr | ov | un) : 0;
        mCapValid = collectData;
        if (collectData) begin
            case (testMode)
                2'd0: src = int'(adcData);
                2'd1: src = mRamp;
                2'd2: src = mLfsr >> (16 - ADC_WIDTH);
                default: src = 1 << (ADC_WIDTH - 1);
            endcase
            mCapSample = src;
            mRamp = (mRamp + 1) % (1 << ADC_WIDTH);
            mLfsr = ((mLfsr << 1) | (^(mLfsr & 16'hB400))) & 16'hFFFF;
        end
        mPrev = collectData;
    endtask

    task automatic check(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: model steps with the DUT on the rising edge; checks follow at the falling edge.
    task automatic tick();
        @(posedge adcClk);
        modelUpdate();
        @(negedge adcClk);
    endtask

    task automatic doReset();
        nReset = 1'b0;
        collectData = 1'b0; readData = 1'b0; testMode = 2'd0; adcData = '0;
        modelReset();
        repeat (2) @(negedge adcClk);
        nReset = 1'b1;
    endtask

    typedef struct {
        logic [1:0]           mode;
        logic [ADC_WIDTH-1:0] adc;
        logic [15:0]          exp;
    } convVec_t;

    convVec_t convTable[7];

    initial begin
        int rdPct;
        int waited;

        convTable[0] = '{2'd2, 10'd0,    16'h2CC0};  // LFSR seed top bits 0x2B3
        convTable[1] = '{2'd1, 10'd0,    16'h8040};  // ramp has stepped once
        convTable[2] = '{2'd0, 10'd0,    16'h8000};
        convTable[3] = '{2'd0, 10'd512,  16'h0000};
        convTable[4] = '{2'd0, 10'd1023, 16'h7FC0};
        convTable[5] = '{2'd3, 10'd5,    16'h0000};
        convTable[6] = '{2'd0, 10'd511,  16'hFFC0};

        doReset();
        check("reset_dataOut", int'(dataOut), 0);
        check("reset_dataAvailable", int'(dataAvailable), 0);
        check("reset_bufferError", int'(bufferError), 0);
        check("reset_usedWords", int'(usedWords), 0);

        // Conversion table: capture one sample, let it land, pop it, check dataOut.
        for (int i = 0; i < 7; i++) begin
            collectData = 1'b1; testMode = convTable[i].mode; adcData = convTable[i].adc;
            tick();
            collectData = 1'b0;
            tick();
            readData = 1'b1;
            tick();
            readData = 1'b0;
            check($sformatf("conv_%0d", i), int'(dataOut), int'(convTable[i].exp));
        end

        // Underflow: read on an empty FIFO while collecting; the same-cycle write still lands.
        collectData = 1'b1; testMode = 2'd0; adcData = 10'd100;
        tick();
        readData = 1'b1;
        tick();
        readData = 1'b0;
        check("underflow_err", int'(bufferError), 1);
        check("underflow_dataOut_held", int'(dataOut), 16'hFFC0);
        check("underflow_write_kept", int'(usedWords), 1);
        collectData = 1'b0;
        tick();
        check("underflow_err_cleared", int'(bufferError), 0);

        // Ramp run: 300 captures, dataAvailable on the 256th write, then read 256 words.
        doReset();
        collectData = 1'b1; testMode = 2'd1;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 256) check("ramp_avail_before", int'(dataAvailable), 0);
            if (i == 257) check("ramp_avail_at_256", int'(dataAvailable), 1);
        end
        collectData = 1'b0;
        tick();
        check("ramp_used_300", int'(usedWords), 300);
        readData = 1'b1;
        for (int i = 0; i < 256; i++) begin
            tick();
            check($sformatf("ramp_word_%0d", i), int'(dataOut), (16'h8000 + i * 16'h40) & 16'hFFFF);
        end
        readData = 1'b0;
        check("ramp_used_44", int'(usedWords), 44);
        check("ramp_avail_low", int'(dataAvailable), 0);

        // Full boundary and overflow.
        doReset();
        collectData = 1'b1; testMode = 2'd3;
        repeat (1025) tick();
        check("full_used", int'(usedWords), FIFO_DEPTH);
        check("full_no_err", int'(bufferError), 0);
        readData = 1'b1;
        tick();
        readData = 1'b0;
        check("full_rw_used", int'(usedWords), FIFO_DEPTH);
        check("full_rw_no_err", int'(bufferError), 0);
        tick();
        check("overflow_used", int'(usedWords), FIFO_DEPTH);
        check("overflow_err", int'(bufferError), 1);
        collectData = 1'b0;
        tick();
        check("overflow_err_cleared", int'(bufferError), 0);

        // Reset mid-capture at 500 words.
        doReset();
        collectData = 1'b1; testMode = 2'd1;
        waited = 0;
        while (usedWords != 500 && waited < 600) begin
            tick();
            waited++;
        end
        check("midreset_reached_500", int'(usedWords), 500);
        #1 nReset = 1'b0;
        modelReset();
        #1;
        check("midreset_dataOut", int'(dataOut), 0);
        check("midreset_avail", int'(dataAvailable), 0);
        check("midreset_err", int'(bufferError), 0);
        check("midreset_used", int'(usedWords), 0);
        #1 nReset = 1'b1;
        repeat (3) tick();
        collectData = 1'b0;
        tick();
        check("midreset_used_3", int'(usedWords), 3);
        readData = 1'b1;
        tick();
        readData = 1'b0;
        check("midreset_ramp_restart", int'(dataOut), 16'h8000);

        // Randomized run against the reference model, read pressure varied per block.
        doReset();
        for (int blk = 0; blk < 7; blk++) begin
            case ($urandom_range(0, 2))
                0: rdPct = 5;
                1: rdPct = 50;
                default: rdPct = 95;
            endcase
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 99) < 3) collectData = ~collectData;
                readData = ($urandom_range(0, 99) < rdPct);
                if ($urandom_range(0, 99) < 5) testMode = 2'($urandom_range(0, 3));
                adcData = ADC_WIDTH'($urandom_range(0, (1 << ADC_WIDTH) - 1));
                tick();
                check("rand_dataOut", int'(dataOut), mOut);
                check("rand_usedWords", int'(usedWords), expQ.size());
                check("rand_dataAvailable", int'(dataAvailable), int'(expQ.size() >= PACKET_WORDS));
                check("rand_bufferError", int'(bufferError), int'(mErr));
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
